// File: rtl/computational_unit_seq.sv
// rtl/computational_unit_seq.sv - register file, bus mux, single-cycle ALU and shift-add multiplier
// Multiply runs W cycles in MUL; the product lands in {r_hi, r} on the last step.
module computational_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       source_sel,
  input  logic [8:0]       reg_en,
  input  logic             i_sel,
  input  logic             x_sel,
  input  logic             y_sel,
  input  logic [3:0]       nibble_ir,
  input  logic [WIDTH-1:0] pm_data,
  input  logic [WIDTH-1:0] dm,
  input  logic [WIDTH-1:0] i_pins,
  output logic [WIDTH-1:0] data_bus,
  output logic [WIDTH-1:0] o_reg,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state;

  logic [WIDTH-1:0]   x0, x1, y0, y1, m;
  logic [WIDTH-1:0]   alu_x, alu_y, alu_res;
  logic               alu_carry, alu_cy_en, alu_nop;
  logic [2:0]         func;
  logic               mode, accept, start;
  logic [2*WIDTH-1:0] mul_cand, mul_acc, mul_sum;
  logic [WIDTH-1:0]   mul_plier;
  logic [CW-1:0]      mul_cnt;
  logic               unused_bits;

  assign unused_bits = reg_en[7];
  assign func   = nibble_ir[2:0];
  assign mode   = nibble_ir[3];
  assign alu_x  = x_sel ? x1 : x0;
  assign alu_y  = y_sel ? y1 : y0;
  assign accept = reg_en[4] && (state != MUL);
  assign start  = accept && (func == 3'd3);
  assign mul_sum = mul_acc + (mul_plier[0] ? mul_cand : '0);

  always_comb begin
    data_bus = '0;
    case (source_sel)
      4'd0:  data_bus = x0;
      4'd1:  data_bus = x1;
      4'd2:  data_bus = y0;
      4'd3:  data_bus = y1;
      4'd4:  data_bus = r;
      4'd5:  data_bus = m;
      4'd6:  data_bus = i;
      4'd7:  data_bus = dm;
      4'd8:  data_bus = pm_data;
      4'd9:  data_bus = i_pins;
      4'd10: data_bus = r_hi;
      default: data_bus = '0;
    endcase
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_cy_en = 1'b0;
    alu_nop   = 1'b0;
    case (func)
      3'd0: begin alu_res = '0 - alu_x; alu_nop = mode; end
      3'd1: begin {alu_carry, alu_res} = {1'b0, alu_x} - {1'b0, alu_y}; alu_cy_en = 1'b1; end
      3'd2: begin {alu_carry, alu_res} = {1'b0, alu_x} + {1'b0, alu_y}; alu_cy_en = 1'b1; end
      3'd4: alu_res = alu_x ^ alu_y;
      3'd5: alu_res = alu_x & alu_y;
      3'd6: alu_res = alu_x | alu_y;
      3'd7: begin alu_res = ~alu_x; alu_nop = mode; end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0 <= '0; x1 <= '0; y0 <= '0; y1 <= '0; m <= '0;
      o_reg <= '0; i <= '0; r <= '0; r_hi <= '0;
      zero_flag <= 1'b1; carry_flag <= 1'b0;
      busy <= 1'b0; done <= 1'b0; state <= IDLE;
      mul_cand <= '0; mul_acc <= '0; mul_plier <= '0; mul_cnt <= '0;
    end else begin
      if (reg_en[0]) x0 <= data_bus;
      if (reg_en[1]) x1 <= data_bus;
      if (reg_en[2]) y0 <= data_bus;
      if (reg_en[3]) y1 <= data_bus;
      if (reg_en[5]) m <= data_bus;
      if (reg_en[8]) o_reg <= data_bus;
      if (reg_en[6]) i <= i_sel ? i + m : data_bus;

      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            // Operands are captured here so later x/y writes cannot disturb the product.
            mul_cand  <= {{WIDTH{1'b0}}, alu_x};
            mul_plier <= alu_y;
            mul_acc   <= '0;
            mul_cnt   <= '0;
            busy      <= 1'b1;
            state     <= MUL;
          end else if (accept && !alu_nop) begin
            r         <= alu_res;
            zero_flag <= (alu_res == '0);
            if (alu_cy_en) carry_flag <= alu_carry;
          end
        end
        MUL: begin
          mul_acc   <= mul_sum;
          mul_cand  <= mul_cand << 1;
          mul_plier <= mul_plier >> 1;
          mul_cnt   <= mul_cnt + CW'(1);
          if (mul_cnt == CW'(WIDTH - 1)) begin
            r          <= mul_sum[WIDTH-1:0];
            r_hi       <= mul_sum[2*WIDTH-1:WIDTH];
            zero_flag  <= (mul_sum[WIDTH-1:0] == '0);
            carry_flag <= (mul_sum[2*WIDTH-1:WIDTH] != '0);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
